tl_client_arbiter_2to1: RTL and testbench
=========================================

# tl_client_arbiter_2to1

Two-client TileLink-UL/UH arbiter sharing one 64-bit manager port. It is placed ahead of the FIFO-fixer/monitor stage on the periphery bus. A-channel requests are granted round-robin, with the grant locked for multi-beat data bursts. The client index is folded into the outbound source ID, D-channel responses are routed back by that bit, and each client's in-flight request count is capped.

## Interface
- MAX_INFLIGHT, 4: maximum accepted-but-unanswered requests per client (1..15).
- clock  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low: state is reset on a clock edge where reset==0.
- auto_in0_a_valid / auto_in0_a_ready  input / output  1/1  client 0 A handshake.
- auto_in0_a_bits_{opcode,param,size,source,address,mask,data,corrupt}  input  3/3/3/3/32/8/64/1  client 0 A payload. source[2:0] is used; source[3] must be 0.
- auto_in0_d_valid / auto_in0_d_ready  output / input  1/1  client 0 D handshake.
- auto_in0_d_bits_{opcode,size,source,denied,data,corrupt}  output  3/3/4/1/64/1  client 0 D payload. source = {1'b0, out source[2:0]}.
- auto_in1_*  same set as auto_in0_*  client 1.
- auto_out_a_valid / auto_out_a_ready  output / input  1/1  manager A handshake.
- auto_out_a_bits_{opcode,param,size,source,address,mask,data,corrupt}  output  3/3/3/4/32/8/64/1  manager A payload. source = {client, in source[2:0]}.
- auto_out_d_valid / auto_out_d_ready  input / output  1/1  manager D handshake.
- auto_out_d_bits_{opcode,size,source,denied,data,corrupt}  input  3/3/4/1/64/1  manager D payload.

## Operation
- Beat count for a message carrying data: 1 if size<=3, else 1<<(size-3). The maximum size is 6, giving 8 beats.
- A carries data when opcode[2]==0 (Put/Arithmetic/Logical). D carries data when opcode is 1 or 5.
- Eligibility: client k is eligible when in_k_a_valid && inflight_k < MAX_INFLIGHT. In BURST state, eligibility is forced for the locked client.
- A FSM, state IDLE:
  - If one client is eligible, grant it.
  - If both are eligible, grant the client that is not last_grant (round-robin).
  - Grant is combinational; out_a_* is muxed from the granted client.
  - in_k_a_ready = out_a_ready && grant==k && eligible_k. The non-granted client sees ready 0.
- A transitions:
  - A first-beat fire updates last_grant to the granted client.
  - If that beat carries data and beats>1: a_rem <= beats-1, lock the grant, go to BURST.
- A FSM, state BURST:
  - Only the locked client is forwarded; the other client's valid is ignored.
  - Each fire decrements a_rem. A fire with a_rem==1 returns to IDLE.
  - The in-flight cap does not block burst continuation beats.
- in-flight counters (4 bits per client):
  - +1 on that client's A first-beat fire.
  - -1 on the last beat of a D message routed to that client.
  - Simultaneous +1 and -1 leave the counter unchanged.
  - Underflow or overflow is a protocol error; the counter saturates and is not wrapped.
- D routing: k = out_d_bits_source[3]. in_k_d_valid = out_d_valid && (source[3]==k); other D fields are broadcast. out_d_ready = in_k_d_ready of the addressed client.
- D last-beat tracking: a single counter d_rem (3 bits). The manager guarantees D bursts are not interleaved.
  - D first-beat fire of a multi-beat data message loads d_rem = beats-1.
  - Each later fire decrements d_rem. The beat is last when d_rem==0 after a single-beat message, or at the fire with d_rem==1.
- No payload is registered; the block adds zero latency on A and D.

## Timing
- Reset (reset==0 at an edge): state=IDLE, last_grant=1 (so client 0 wins the first tie), a_rem=0, d_rem=0, inflight_0=inflight_1=0.
- Outputs are combinational from inputs plus state. After reset:
  - auto_out_a_valid=0 while no client is valid.
  - in_k_a_ready=0 for a client that is not valid or not granted.
  - auto_out_d_ready=0 while out_d_valid=0 or the addressed client's d_ready=0.
- The grant is stable while out_a_valid && !out_a_ready. The granted client is not switched mid-handshake, because TileLink holds valid.
- Reset asserted mid-burst: the FSM returns to IDLE and the counters clear. Upstream and downstream are reset in the same domain.
- A and D fires in the same cycle are fully independent.
- A first-beat fire and the last D beat for the same client in one cycle: the in-flight count is unchanged.

## Test plan
- Both clients issue a single-beat Get (opcode 4, size 3) in the same cycle after reset. Required response: client 0 is granted first with out source=0x0_src, then client 1 with out source=0x8|src. They continue to alternate under persistent contention.
- Client 1 sends PutFull with size 6 (8 beats) while client 0 stays valid. Required response: all 8 beats go to client 1 with no client-0 beat interleaved. Client 0 is granted on the cycle after the 8th beat fires.
- A manager D response with source 0xB, AccessAckData, size 5. Required response: 4 beats reach client 1 with source 0x3. in1 inflight decrements only on the 4th beat. in0_d_valid stays 0.
- Client 0 issues 4 Gets with no responses, MAX_INFLIGHT=4. Required response: the 5th Get sees ready 0. One AccessAck to client 0 re-enables acceptance on the following cycle.
- out_a_ready is held 0 for 5 cycles with both clients valid. Required response: the grant and out_a_* stay constant, and no counter changes.
- reset driven 0 for one edge in the middle of a burst (a_rem=3). Required response: the next cycle is IDLE, the counters are 0, and a tie goes to client 0.

Source files
------------

// File: rtl/tl_client_arbiter_2to1.sv
// tl_client_arbiter_2to1
// Two-client TileLink-UL/UH arbiter in front of a single 64-bit manager port.
//   clock, reset           : single clock; reset is synchronous and active-low
//   auto_in0_* / auto_in1_*: client A (request) and D (response) channels
//   auto_out_*             : manager A and D channels
// A requests are granted round-robin and the grant is locked for multi-beat
// data bursts. The client index becomes bit 3 of the outbound source, and D
// responses are steered back by that bit. Each client's accepted-but-unanswered
// request count is capped at MAX_INFLIGHT. No payload is registered, so the
// block adds no latency on either channel.
module tl_client_arbiter_2to1 #(
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        auto_in0_a_valid,
    output logic        auto_in0_a_ready,
    input  logic [2:0]  auto_in0_a_bits_opcode,
    input  logic [2:0]  auto_in0_a_bits_param,
    input  logic [2:0]  auto_in0_a_bits_size,
    input  logic [2:0]  auto_in0_a_bits_source,
    input  logic [31:0] auto_in0_a_bits_address,
    input  logic [7:0]  auto_in0_a_bits_mask,
    input  logic [63:0] auto_in0_a_bits_data,
    input  logic        auto_in0_a_bits_corrupt,
    output logic        auto_in0_d_valid,
    input  logic        auto_in0_d_ready,
    output logic [2:0]  auto_in0_d_bits_opcode,
    output logic [2:0]  auto_in0_d_bits_size,
    output logic [3:0]  auto_in0_d_bits_source,
    output logic        auto_in0_d_bits_denied,
    output logic [63:0] auto_in0_d_bits_data,
    output logic        auto_in0_d_bits_corrupt,
    input  logic        auto_in1_a_valid,
    output logic        auto_in1_a_ready,
    input  logic [2:0]  auto_in1_a_bits_opcode,
    input  logic [2:0]  auto_in1_a_bits_param,
    input  logic [2:0]  auto_in1_a_bits_size,
    input  logic [2:0]  auto_in1_a_bits_source,
    input  logic [31:0] auto_in1_a_bits_address,
    input  logic [7:0]  auto_in1_a_bits_mask,
    input  logic [63:0] auto_in1_a_bits_data,
    input  logic        auto_in1_a_bits_corrupt,
    output logic        auto_in1_d_valid,
    input  logic        auto_in1_d_ready,
    output logic [2:0]  auto_in1_d_bits_opcode,
    output logic [2:0]  auto_in1_d_bits_size,
    output logic [3:0]  auto_in1_d_bits_source,
    output logic        auto_in1_d_bits_denied,
    output logic [63:0] auto_in1_d_bits_data,
    output logic        auto_in1_d_bits_corrupt,
    output logic        auto_out_a_valid,
    input  logic        auto_out_a_ready,
    output logic [2:0]  auto_out_a_bits_opcode,
    output logic [2:0]  auto_out_a_bits_param,
    output logic [2:0]  auto_out_a_bits_size,
    output logic [3:0]  auto_out_a_bits_source,
    output logic [31:0] auto_out_a_bits_address,
    output logic [7:0]  auto_out_a_bits_mask,
    output logic [63:0] auto_out_a_bits_data,
    output logic        auto_out_a_bits_corrupt,
    input  logic        auto_out_d_valid,
    output logic        auto_out_d_ready,
    input  logic [2:0]  auto_out_d_bits_opcode,
    input  logic [2:0]  auto_out_d_bits_size,
    input  logic [3:0]  auto_out_d_bits_source,
    input  logic        auto_out_d_bits_denied,
    input  logic [63:0] auto_out_d_bits_data,
    input  logic        auto_out_d_bits_corrupt
);

    typedef enum logic [0:0] {
        A_IDLE  = 1'b0,
        A_BURST = 1'b1
    } a_state_e;

    localparam logic [3:0] MAX_CNT = 4'(MAX_INFLIGHT);

    // Beats minus one of a data-carrying message (size 6 -> 8 beats -> 7).
    function automatic logic [2:0] beats_minus_one(input logic [2:0] size);
        logic [2:0] bm1;
        case (size)
            3'd4:    bm1 = 3'd1;
            3'd5:    bm1 = 3'd3;
            3'd6:    bm1 = 3'd7;
            3'd7:    bm1 = 3'd7;
            default: bm1 = 3'd0;
        endcase
        return bm1;
    endfunction

    // Saturating in-flight update; a simultaneous +1/-1 cancels out.
    function automatic logic [3:0] inflight_next(input logic [3:0] cnt, input logic inc, input logic dec);
        logic [3:0] nxt;
        if (inc && !dec && (cnt != 4'hF)) begin
            nxt = cnt + 4'd1;
        end else if (dec && !inc && (cnt != 4'h0)) begin
            nxt = cnt - 4'd1;
        end else begin
            nxt = cnt;
        end
        return nxt;
    endfunction

    a_state_e   state_r, state_nxt_s;
    logic       last_grant_r;
    logic       lock_r;
    logic       hold_r;        // previous cycle offered a beat that stalled
    logic       hold_grant_r;
    logic [2:0] a_rem_r, a_rem_nxt_s;
    logic [2:0] d_rem_r, d_rem_nxt_s;
    logic [3:0] inflight0_r, inflight1_r;

    logic       elig0_s, elig1_s, grant_s;
    logic       a_fire_s, first_fire_s;
    logic [2:0] a_bm1_s;
    logic       d_dst_s, d_fire_s, d_last_s;
    logic [2:0] d_bm1_s;

    // Eligibility: in a burst only the locked client counts and the cap is bypassed.
    always_comb begin
        elig0_s = 1'b0;
        elig1_s = 1'b0;
        if (state_r == A_BURST) begin
            elig0_s = auto_in0_a_valid && (lock_r == 1'b0);
            elig1_s = auto_in1_a_valid && (lock_r == 1'b1);
        end else begin
            elig0_s = auto_in0_a_valid && (inflight0_r < MAX_CNT);
            elig1_s = auto_in1_a_valid && (inflight1_r < MAX_CNT);
        end
    end

    // Grant selection. A stalled offer keeps its client so that a D response
    // freeing the other client's cap cannot switch the grant mid-handshake.
    always_comb begin
        grant_s = 1'b0;
        if (state_r == A_BURST) begin
            grant_s = lock_r;
        end else if (hold_r && (hold_grant_r ? elig1_s : elig0_s)) begin
            grant_s = hold_grant_r;
        end else if (elig0_s && elig1_s) begin
            grant_s = ~last_grant_r;
        end else if (elig1_s) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    assign auto_out_a_valid        = grant_s ? elig1_s : elig0_s;
    assign auto_out_a_bits_opcode  = grant_s ? auto_in1_a_bits_opcode  : auto_in0_a_bits_opcode;
    assign auto_out_a_bits_param   = grant_s ? auto_in1_a_bits_param   : auto_in0_a_bits_param;
    assign auto_out_a_bits_size    = grant_s ? auto_in1_a_bits_size    : auto_in0_a_bits_size;
    assign auto_out_a_bits_source  = {grant_s, grant_s ? auto_in1_a_bits_source : auto_in0_a_bits_source};
    assign auto_out_a_bits_address = grant_s ? auto_in1_a_bits_address : auto_in0_a_bits_address;
    assign auto_out_a_bits_mask    = grant_s ? auto_in1_a_bits_mask    : auto_in0_a_bits_mask;
    assign auto_out_a_bits_data    = grant_s ? auto_in1_a_bits_data    : auto_in0_a_bits_data;
    assign auto_out_a_bits_corrupt = grant_s ? auto_in1_a_bits_corrupt : auto_in0_a_bits_corrupt;

    assign auto_in0_a_ready = auto_out_a_ready && (grant_s == 1'b0) && elig0_s;
    assign auto_in1_a_ready = auto_out_a_ready && (grant_s == 1'b1) && elig1_s;

    assign a_fire_s     = auto_out_a_valid && auto_out_a_ready;
    assign first_fire_s = a_fire_s && (state_r == A_IDLE);
    assign a_bm1_s      = auto_out_a_bits_opcode[2] ? 3'd0 : beats_minus_one(auto_out_a_bits_size);

    // A-channel burst FSM: next state and remaining beat count.
    always_comb begin
        state_nxt_s = state_r;
        a_rem_nxt_s = a_rem_r;
        case (state_r)
            A_IDLE: begin
                if (first_fire_s && (a_bm1_s != 3'd0)) begin
                    state_nxt_s = A_BURST;
                    a_rem_nxt_s = a_bm1_s;
                end else begin
                    state_nxt_s = A_IDLE;
                end
            end
            A_BURST: begin
                if (a_fire_s) begin
                    a_rem_nxt_s = a_rem_r - 3'd1;
                    if (a_rem_r == 3'd1) begin
                        state_nxt_s = A_IDLE;
                    end else begin
                        state_nxt_s = A_BURST;
                    end
                end else begin
                    state_nxt_s = A_BURST;
                end
            end
            default: begin
                state_nxt_s = A_IDLE;
                a_rem_nxt_s = 3'd0;
            end
        endcase
    end

    // D routing: bit 3 of the manager source selects the client.
    assign d_dst_s          = auto_out_d_bits_source[3];
    assign auto_in0_d_valid = auto_out_d_valid && !d_dst_s;
    assign auto_in1_d_valid = auto_out_d_valid && d_dst_s;
    assign auto_out_d_ready = auto_out_d_valid && (d_dst_s ? auto_in1_d_ready : auto_in0_d_ready);
    assign d_fire_s         = auto_out_d_valid && auto_out_d_ready;

    assign auto_in0_d_bits_opcode  = auto_out_d_bits_opcode;
    assign auto_in0_d_bits_size    = auto_out_d_bits_size;
    assign auto_in0_d_bits_source  = {1'b0, auto_out_d_bits_source[2:0]};
    assign auto_in0_d_bits_denied  = auto_out_d_bits_denied;
    assign auto_in0_d_bits_data    = auto_out_d_bits_data;
    assign auto_in0_d_bits_corrupt = auto_out_d_bits_corrupt;
    assign auto_in1_d_bits_opcode  = auto_out_d_bits_opcode;
    assign auto_in1_d_bits_size    = auto_out_d_bits_size;
    assign auto_in1_d_bits_source  = {1'b0, auto_out_d_bits_source[2:0]};
    assign auto_in1_d_bits_denied  = auto_out_d_bits_denied;
    assign auto_in1_d_bits_data    = auto_out_d_bits_data;
    assign auto_in1_d_bits_corrupt = auto_out_d_bits_corrupt;

    assign d_bm1_s = ((auto_out_d_bits_opcode == 3'd1) || (auto_out_d_bits_opcode == 3'd5))
                     ? beats_minus_one(auto_out_d_bits_size) : 3'd0;

    // D last-beat detection; d_rem_r==0 means the next fire is a first beat.
    always_comb begin
        d_last_s    = 1'b0;
        d_rem_nxt_s = d_rem_r;
        if (d_rem_r == 3'd0) begin
            d_last_s = d_fire_s && (d_bm1_s == 3'd0);
            if (d_fire_s) begin
                d_rem_nxt_s = d_bm1_s;
            end else begin
                d_rem_nxt_s = d_rem_r;
            end
        end else begin
            d_last_s = d_fire_s && (d_rem_r == 3'd1);
            if (d_fire_s) begin
                d_rem_nxt_s = d_rem_r - 3'd1;
            end else begin
                d_rem_nxt_s = d_rem_r;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r      <= A_IDLE;
            last_grant_r <= 1'b1;
            lock_r       <= 1'b0;
            hold_r       <= 1'b0;
            hold_grant_r <= 1'b0;
            a_rem_r      <= 3'd0;
            d_rem_r      <= 3'd0;
            inflight0_r  <= 4'd0;
            inflight1_r  <= 4'd0;
        end else begin
            state_r      <= state_nxt_s;
            a_rem_r      <= a_rem_nxt_s;
            d_rem_r      <= d_rem_nxt_s;
            hold_r       <= (state_r == A_IDLE) && auto_out_a_valid && !auto_out_a_ready;
            hold_grant_r <= grant_s;
            if (first_fire_s) begin
                last_grant_r <= grant_s;
                lock_r       <= grant_s;
            end
            inflight0_r <= inflight_next(inflight0_r, first_fire_s && !grant_s, d_last_s && !d_dst_s);
            inflight1_r <= inflight_next(inflight1_r, first_fire_s && grant_s, d_last_s && d_dst_s);
        end
    end

endmodule

// File: tb/tb_tl_client_arbiter_2to1.sv
// Self-checking bench for tl_client_arbiter_2to1: directed scenarios plus a
// randomized phase, all checked every cycle against a message-level model.
module tb_tl_client_arbiter_2to1;
    localparam int MAXI = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    // Client-side A drive and D ready
    logic        a_valid[2];
    logic [2:0]  a_opcode[2], a_param[2], a_size[2], a_source[2];
    logic [31:0] a_address[2];
    logic [7:0]  a_mask[2];
    logic [63:0] a_data[2];
    logic        a_corrupt[2];
    logic        d_ready_in[2];
    // Manager-side drive
    logic        out_a_ready;
    logic        d_valid;
    logic [2:0]  d_opcode, d_size;
    logic [3:0]  d_source;
    logic        d_denied, d_corrupt;
    logic [63:0] d_data;
    // DUT outputs
    logic        in0_a_ready, in1_a_ready, in0_d_valid, in1_d_valid;
    logic [2:0]  in0_d_opcode, in0_d_size, in1_d_opcode, in1_d_size;
    logic [3:0]  in0_d_source, in1_d_source;
    logic        in0_d_denied, in0_d_corrupt, in1_d_denied, in1_d_corrupt;
    logic [63:0] in0_d_data, in1_d_data;
    logic        out_a_valid, out_a_corrupt, out_d_ready;
    logic [2:0]  out_a_opcode, out_a_param, out_a_size;
    logic [3:0]  out_a_source;
    logic [31:0] out_a_address;
    logic [7:0]  out_a_mask;
    logic [63:0] out_a_data;

    tl_client_arbiter_2to1 #(.MAX_INFLIGHT(MAXI)) dut (
        .clock(clock), .reset(reset),
        .auto_in0_a_valid(a_valid[0]), .auto_in0_a_ready(in0_a_ready),
        .auto_in0_a_bits_opcode(a_opcode[0]), .auto_in0_a_bits_param(a_param[0]),
        .auto_in0_a_bits_size(a_size[0]), .auto_in0_a_bits_source(a_source[0]),
        .auto_in0_a_bits_address(a_address[0]), .auto_in0_a_bits_mask(a_mask[0]),
        .auto_in0_a_bits_data(a_data[0]), .auto_in0_a_bits_corrupt(a_corrupt[0]),
        .auto_in0_d_valid(in0_d_valid), .auto_in0_d_ready(d_ready_in[0]),
        .auto_in0_d_bits_opcode(in0_d_opcode), .auto_in0_d_bits_size(in0_d_size),
        .auto_in0_d_bits_source(in0_d_source), .auto_in0_d_bits_denied(in0_d_denied),
        .auto_in0_d_bits_data(in0_d_data), .auto_in0_d_bits_corrupt(in0_d_corrupt),
        .auto_in1_a_valid(a_valid[1]), .auto_in1_a_ready(in1_a_ready),
        .auto_in1_a_bits_opcode(a_opcode[1]), .auto_in1_a_bits_param(a_param[1]),
        .auto_in1_a_bits_size(a_size[1]), .auto_in1_a_bits_source(a_source[1]),
        .auto_in1_a_bits_address(a_address[1]), .auto_in1_a_bits_mask(a_mask[1]),
        .auto_in1_a_bits_data(a_data[1]), .auto_in1_a_bits_corrupt(a_corrupt[1]),
        .auto_in1_d_valid(in1_d_valid), .auto_in1_d_ready(d_ready_in[1]),
        .auto_in1_d_bits_opcode(in1_d_opcode), .auto_in1_d_bits_size(in1_d_size),
        .auto_in1_d_bits_source(in1_d_source), .auto_in1_d_bits_denied(in1_d_denied),
        .auto_in1_d_bits_data(in1_d_data), .auto_in1_d_bits_corrupt(in1_d_corrupt),
        .auto_out_a_valid(out_a_valid), .auto_out_a_ready(out_a_ready),
        .auto_out_a_bits_opcode(out_a_opcode), .auto_out_a_bits_param(out_a_param),
        .auto_out_a_bits_size(out_a_size), .auto_out_a_bits_source(out_a_source),
        .auto_out_a_bits_address(out_a_address), .auto_out_a_bits_mask(out_a_mask),
        .auto_out_a_bits_data(out_a_data), .auto_out_a_bits_corrupt(out_a_corrupt),
        .auto_out_d_valid(d_valid), .auto_out_d_ready(out_d_ready),
        .auto_out_d_bits_opcode(d_opcode), .auto_out_d_bits_size(d_size),
        .auto_out_d_bits_source(d_source), .auto_out_d_bits_denied(d_denied),
        .auto_out_d_bits_data(d_data), .auto_out_d_bits_corrupt(d_corrupt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Message-level reference model
    int m_last, m_burst, m_owner, m_left, m_hold, m_hold_c;
    int m_infl[2];
    // Per-cycle expectations
    int e_g, e_dk;
    bit e_valid, e_afire, e_dfire;
    // Stimulus state and knobs
    int c_left[2];      // beats still to send of the client's current message
    bit a_keep[2];      // offered beat not yet accepted -> must be held
    bit d_keep;
    int mg_pend[2];     // accepted requests not yet answered by the manager
    int mg_left;        // beats left of the current D message
    int gen_pct[2], op_fix[2], size_fix[2];
    int gap_pct, rdy_pct, mgr_pct, dr_pct;

    function automatic int beats_of(input int size);
        return (size <= 3) ? 1 : (1 << (size - 3));
    endfunction

    task automatic new_msg(input int k);
        int op;
        int sz;
        if (op_fix[k] >= 0) op = op_fix[k];
        else op = $urandom_range(4);
        if (size_fix[k] >= 0) sz = size_fix[k];
        else sz = $urandom_range(6);
        a_opcode[k]  = 3'(op);
        a_size[k]    = 3'(sz);
        a_param[k]   = 3'($urandom_range(7));
        a_source[k]  = 3'($urandom_range(7));
        a_address[k] = $urandom;
        a_mask[k]    = 8'($urandom);
        a_data[k]    = {$urandom, $urandom};
        a_corrupt[k] = 1'($urandom_range(1));
        c_left[k]    = (op < 4) ? beats_of(sz) : 1;
        a_valid[k]   = 1'b1;
    endtask

    task automatic mgr_issue(input int k, input int op, input int sz, input logic [2:0] lo);
        mg_pend[k]--;
        d_opcode  = 3'(op);
        d_size    = 3'(sz);
        d_source  = {(k == 1) ? 1'b1 : 1'b0, lo};
        d_denied  = 1'($urandom_range(1));
        d_corrupt = 1'b0;
        d_data    = {$urandom, $urandom};
        mg_left   = (op == 1) ? beats_of(sz) : 1;
        d_valid   = 1'b1;
        d_keep    = 1'b1;
    endtask

    task automatic drive();
        for (int k = 0; k < 2; k++) begin
            if (!a_keep[k]) begin
                if (c_left[k] > 0) begin
                    a_valid[k] = ($urandom_range(99) >= gap_pct);
                    a_data[k]  = {$urandom, $urandom};
                    a_mask[k]  = 8'($urandom);
                end else if ($urandom_range(99) < gen_pct[k]) begin
                    new_msg(k);
                end else begin
                    a_valid[k] = 1'b0;
                end
            end
            d_ready_in[k] = ($urandom_range(99) < dr_pct);
        end
        out_a_ready = ($urandom_range(99) < rdy_pct);
        if (!d_keep) begin
            if (mg_left > 0) begin
                d_valid = ($urandom_range(99) >= gap_pct);
                d_data  = {$urandom, $urandom};
            end else if (($urandom_range(99) < mgr_pct) && (mg_pend[0] + mg_pend[1] > 0)) begin
                int k;
                if (mg_pend[0] > 0 && mg_pend[1] > 0) k = $urandom_range(1);
                else k = (mg_pend[0] > 0) ? 0 : 1;
                mgr_issue(k, $urandom_range(1), $urandom_range(6), 3'($urandom_range(7)));
            end else begin
                d_valid = 1'b0;
            end
        end
    endtask

    // Drive this cycle's inputs, then compare every output with the model.
    task automatic cycle_pre();
        bit el[2];
        logic eg;
        logic [3:0] dsrc_exp;
        drive();
        #3;
        for (int k = 0; k < 2; k++) el[k] = a_valid[k] && (m_infl[k] < MAXI);
        if (m_burst != 0) begin
            e_g     = m_owner;
            e_valid = a_valid[m_owner];
        end else begin
            if (m_hold != 0 && el[m_hold_c]) e_g = m_hold_c;
            else if (el[0] && el[1]) e_g = 1 - m_last;
            else if (el[1]) e_g = 1;
            else e_g = 0;
            e_valid = el[e_g];
        end
        e_afire = e_valid && out_a_ready;
        eg = (e_g == 1);
        check_eq("out_a_valid", 128'(out_a_valid), 128'(e_valid));
        if (e_valid) begin
            check_eq("out_a_payload",
                128'({out_a_opcode, out_a_param, out_a_size, out_a_source, out_a_address, out_a_mask, out_a_data, out_a_corrupt}),
                128'({a_opcode[e_g], a_param[e_g], a_size[e_g], eg, a_source[e_g], a_address[e_g], a_mask[e_g], a_data[e_g], a_corrupt[e_g]}));
        end
        check_eq("in0_a_ready", 128'(in0_a_ready), 128'(out_a_ready && e_valid && e_g == 0));
        check_eq("in1_a_ready", 128'(in1_a_ready), 128'(out_a_ready && e_valid && e_g == 1));
        e_dk    = d_source[3] ? 1 : 0;
        e_dfire = d_valid && d_ready_in[e_dk];
        check_eq("in0_d_valid", 128'(in0_d_valid), 128'(d_valid && e_dk == 0));
        check_eq("in1_d_valid", 128'(in1_d_valid), 128'(d_valid && e_dk == 1));
        check_eq("out_d_ready", 128'(out_d_ready), 128'(e_dfire));
        if (d_valid) begin
            dsrc_exp = {1'b0, d_source[2:0]};
            if (e_dk == 0)
                check_eq("in0_d_payload", 128'({in0_d_opcode, in0_d_size, in0_d_source, in0_d_denied, in0_d_data, in0_d_corrupt}),
                         128'({d_opcode, d_size, dsrc_exp, d_denied, d_data, d_corrupt}));
            else
                check_eq("in1_d_payload", 128'({in1_d_opcode, in1_d_size, in1_d_source, in1_d_denied, in1_d_data, in1_d_corrupt}),
                         128'({d_opcode, d_size, dsrc_exp, d_denied, d_data, d_corrupt}));
        end
    endtask

    // Clock edge, then advance the model and the stimulus generators.
    task automatic cycle_post();
        @(posedge clock);
        #1;
        m_hold   = (m_burst == 0 && e_valid && !out_a_ready) ? 1 : 0;
        m_hold_c = e_g;
        if (e_afire) begin
            if (m_burst == 0) begin
                m_last = e_g;
                m_infl[e_g]++;
                mg_pend[e_g]++;
                if (c_left[e_g] > 1) begin
                    m_burst = 1;
                    m_owner = e_g;
                    m_left  = c_left[e_g] - 1;
                end
            end else begin
                m_left--;
                if (m_left == 0) m_burst = 0;
            end
            c_left[e_g]--;
        end
        for (int k = 0; k < 2; k++) a_keep[k] = a_valid[k] && !(e_afire && e_g == k);
        if (e_dfire) begin
            mg_left--;
            if (mg_left == 0) m_infl[e_dk]--;
        end
        d_keep = d_valid && !e_dfire;
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            cycle_pre();
            cycle_post();
        end
    endtask

    task automatic set_knobs(input int g0, input int g1, input int op, input int sz,
                             input int gap, input int rdy, input int mgr, input int dr);
        gen_pct[0] = g0;  gen_pct[1] = g1;
        op_fix[0]  = op;  op_fix[1]  = op;
        size_fix[0] = sz; size_fix[1] = sz;
        gap_pct = gap; rdy_pct = rdy; mgr_pct = mgr; dr_pct = dr;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            a_valid[k] = 1'b0; a_keep[k] = 1'b0; c_left[k] = 0;
            m_infl[k] = 0; mg_pend[k] = 0; d_ready_in[k] = 1'b0;
        end
        d_valid = 1'b0; d_keep = 1'b0; mg_left = 0; out_a_ready = 1'b0;
        m_last = 1; m_burst = 0; m_owner = 0; m_left = 0; m_hold = 0; m_hold_c = 0;
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            a_opcode[k] = 3'd4; a_param[k] = 3'd0; a_size[k] = 3'd3; a_source[k] = 3'd0;
            a_address[k] = 32'd0; a_mask[k] = 8'd0; a_data[k] = 64'd0; a_corrupt[k] = 1'b0;
        end
        d_opcode = 3'd0; d_size = 3'd0; d_source = 4'd0; d_denied = 1'b0; d_corrupt = 1'b0; d_data = 64'd0;

        // Idle after reset: nothing valid, nothing ready.
        set_knobs(0, 0, -1, -1, 0, 100, 0, 100);
        do_reset();
        cyc(3);

        // Tie of single-beat Gets: client 0 first, then strict alternation until both are capped.
        do_reset();
        set_knobs(100, 100, 4, 3, 0, 100, 0, 100);
        for (int i = 0; i < 8; i++) begin
            cycle_pre();
            check_eq("tie_client", 128'(out_a_source[3]), 128'(i % 2));
            check_eq("tie_src", 128'(out_a_source[2:0]), 128'(a_source[i % 2]));
            cycle_post();
        end
        cycle_pre();
        check_eq("both_capped", 128'(out_a_valid), 128'(0));
        cycle_post();

        // Cap: 4 Gets from client 0, 5th blocked until one AccessAck returns.
        do_reset();
        set_knobs(100, 0, 4, 3, 0, 100, 0, 100);
        cyc(4);
        cycle_pre();
        check_eq("cap_block", 128'(in0_a_ready), 128'(0));
        cycle_post();
        mgr_issue(0, 0, 3, 3'd2);
        cycle_pre();
        check_eq("cap_ack_cycle", 128'(in0_a_ready), 128'(0));
        cycle_post();
        cycle_pre();
        check_eq("cap_release", 128'(in0_a_ready), 128'(1));
        cycle_post();

        // 8-beat PutFull from client 1 while client 0 waits.
        do_reset();
        set_knobs(0, 100, 0, 6, 0, 100, 0, 100);
        cycle_pre();
        check_eq("burst_first", 128'(out_a_source[3]), 128'(1));
        cycle_post();
        gen_pct[0] = 100; op_fix[0] = 4; size_fix[0] = 3; gen_pct[1] = 0;
        for (int i = 0; i < 7; i++) begin
            cycle_pre();
            check_eq("burst_locked", 128'(out_a_source[3]), 128'(1));
            check_eq("burst_in0_rdy", 128'(in0_a_ready), 128'(0));
            cycle_post();
        end
        cycle_pre();
        check_eq("after_burst", 128'({out_a_valid, out_a_source[3]}), 128'(2'b10));
        cycle_post();

        // 4-beat AccessAckData with source 0xB routed to client 1.
        gen_pct[0] = 0;
        mgr_issue(1, 1, 5, 3'd3);
        for (int i = 0; i < 4; i++) begin
            cycle_pre();
            check_eq("dburst_src", 128'(in1_d_source), 128'(4'h3));
            check_eq("dburst_in0_valid", 128'(in0_d_valid), 128'(0));
            check_eq("dburst_in1_valid", 128'(in1_d_valid), 128'(1));
            cycle_post();
        end

        // Manager stalls A for 5 cycles under contention.
        do_reset();
        set_knobs(100, 100, -1, -1, 0, 0, 0, 100);
        cyc(5);
        rdy_pct = 100;
        cyc(6);

        // Reset in the middle of a burst, then a tie goes to client 0.
        do_reset();
        set_knobs(100, 0, 0, 6, 0, 100, 0, 100);
        cyc(5);
        do_reset();
        set_knobs(100, 100, 4, 3, 0, 100, 0, 100);
        cycle_pre();
        check_eq("rst_tie", 128'({out_a_valid, out_a_source[3]}), 128'(2'b10));
        cycle_post();

        // Randomized traffic on both channels.
        do_reset();
        set_knobs(40, 40, -1, -1, 20, 70, 50, 70);
        cyc(3000);
        set_knobs(90, 90, -1, -1, 10, 50, 20, 40);
        cyc(2000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
